srl_bus_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-latency shift-register delay line (a bus-wide SRL chain, DELAY cycles) between NUM_REQ requesters.
- Grants at most one requester per cycle and drives the delay-line input.
- Carries a parallel valid/tag pipeline so each word leaving the delay line is returned to the requester that issued it.
- Provides a drain handshake so software/upstream logic can quiesce the line before reconfiguration.

---
 rtl/srl_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/srl_bus_scheduler.sv | 131 +++++++++++++
 tb/tb_srl_bus_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/srl_sched_pkg.sv
// Shared types for the SRL bus scheduler: FSM state encoding, the per-stage
// tag carried alongside the delay line, and the index-width helper.
package srl_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    // Requester index width: $clog2(n), but never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The tag idx field is sized for the largest supported NUM_REQ (16), so the
    // struct can live in the package; narrower indices are zero-extended.
    localparam int IDX_W_MAX = 4;

    typedef struct packed {
        logic                 valid;
        logic [IDX_W_MAX-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping, returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srl_bus_scheduler.sv
// Round-robin scheduler sharing one external fixed-latency SRL delay line among
// NUM_REQ requesters, with a tag pipe that routes each returned word home.
module srl_bus_scheduler
    import srl_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 8,
    parameter int DELAY     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [BUS_WIDTH-1:0]           srl_din,
    input  logic [BUS_WIDTH-1:0]           srl_dout,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [BUS_WIDTH-1:0]           rsp_data,
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(DELAY + 1);

    sched_state_e     state_q;
    logic             drain_done_q;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tag_t             tag_q [DELAY];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               issue_en, xfer, retire;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // drain_req gates issue combinationally so no word slips in on the request cycle.
    assign issue_en  = (state_q == RUN) && !drain_req && !rst;
    assign req_ready = issue_en ? arb_gnt : '0;
    assign xfer      = issue_en && arb_any;
    assign retire    = tag_q[DELAY-1].valid;

    always_comb begin
        srl_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) srl_din = req_data[i*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = retire && (tag_q[DELAY-1].idx == IDX_W_MAX'(i));
        end
    end

    assign rsp_data   = srl_dout;
    assign busy       = (cnt_q != '0);
    assign drain_done = drain_done_q;

    always_comb begin
        case ({xfer, retire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ptr_d = ptr_q;
        if (xfer) ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int s = 0; s < DELAY; s++) tag_q[s] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tag_q[0].valid <= xfer;
            tag_q[0].idx   <= IDX_W_MAX'(arb_idx);
            for (int s = 1; s < DELAY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // DONE is entered on the edge where the last in-flight word retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (drain_req) begin
                        if (cnt_d == '0) begin
                            state_q      <= DONE;
                            drain_done_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == '0) begin
                        state_q      <= DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        state_q      <= RUN;
                        drain_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= RUN;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srl_bus_scheduler.sv
// Scoreboard bench for srl_bus_scheduler with a behavioural delay line and
// a queue-based model of in-flight words, round-robin order and drain.
module tb_srl_bus_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   srl_din;
    logic [W-1:0]   srl_dout;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           drain_req;
    logic           drain_done;
    logic           busy;

    srl_bus_scheduler #(.NUM_REQ(N), .BUS_WIDTH(W), .DELAY(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .srl_din    (srl_din),
        .srl_dout   (srl_dout),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External delay line: not reset, so stale words survive a reset.
    logic [W-1:0] sreg [D];
    always @(posedge clk) begin
        sreg[0] <= srl_din;
        for (int s = 1; s < D; s++) sreg[s] <= sreg[s-1];
    end
    assign srl_dout = sreg[D-1];

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   m_ptr   = 0;
    bit   m_halted = 1'b0;
    bit   m_done   = 1'b0;
    bit   run_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares returned words and status flags against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (run_done) break;
            chk("busy", 32'(busy), 32'(sb.size() != 0));
            chk("drain_done", 32'(drain_done), 32'(m_done));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic dr, input logic r);
        int           g;
        logic [W-1:0] word;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_data  = d;
        drain_req = dr;
        #1;
        if (r) begin
            sb.delete();
            m_ptr    = 0;
            m_halted = 1'b0;
            m_done   = 1'b0;
            chk("ready_in_rst", 32'(req_ready), 32'(0));
            chk("din_in_rst", 32'(srl_din), 32'(0));
            return;
        end
        g = -1;
        if (!m_halted && !dr) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        word = (g >= 0) ? d[g*W +: W] : '0;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 32'(0));
        chk("srl_din", 32'(srl_din), 32'(word));
        if (g >= 0) begin
            sb.push_back('{idx: g, data: word, due: cyc + D});
            m_ptr = (g + 1) % N;
        end
        // Drain model: halt on request, done once nothing is in flight, resume on release.
        if (!m_halted) begin
            if (dr) begin
                m_halted = 1'b1;
                m_done   = (sb.size() == 0);
            end
        end else if (!m_done) begin
            if (sb.size() == 0) m_done = 1'b1;
        end else if (!dr) begin
            m_halted = 1'b0;
            m_done   = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] x;
        for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom);
        return x;
    endfunction

    initial begin
        logic dr;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        drain_req = 1'b0;
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        idle(3);

        // Single requester 2 with 0xA5.
        step(4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
        idle(6);

        // All requesters valid, data = index: strict rotation.
        for (int i = 0; i < 8; i++) step(4'b1111, 32'h0302_0100, 1'b0, 1'b0);
        idle(6);

        // Traffic, then drain held with requests pending, then release.
        for (int i = 0; i < 10; i++) step(4'($urandom), rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step(4'b1111, rnd_data(), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  step(4'($urandom), rnd_data(), 1'b0, 1'b0);
        idle(6);

        // Three words in flight, then a one-cycle reset; pointer restarts at 0.
        for (int i = 0; i < 3; i++) step(4'b1000, rnd_data(), 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        idle(6);
        step(4'b1111, rnd_data(), 1'b0, 1'b0);
        idle(6);

        // Drain with an empty line, held for five cycles.
        for (int i = 0; i < 5; i++) step(4'($urandom), rnd_data(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0001, rnd_data(), 1'b0, 1'b0);
        idle(6);

        // Single requester held valid: granted every cycle.
        for (int i = 0; i < 6; i++) step(4'b0010, rnd_data(), 1'b0, 1'b0);
        idle(6);

        // Random traffic with random drain toggles and occasional resets.
        dr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 14) == 0) dr = ~dr;
            if ($urandom_range(0, 119) == 0) begin
                dr = 1'b0;
                step('0, '0, 1'b0, 1'b1);
            end else begin
                step(4'($urandom), rnd_data(), dr, 1'b0);
            end
        end
        idle(D + 4);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        run_done = 1'b1;
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
